// File: rtl/operand_reg_bank.sv
// Eight-entry general register bank feeding the Op1/Op2 operand latches.
// Two registered operand reads per request, one write-back per cycle with bypass, pending-destination scoreboard.
module operand_reg_bank #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NREG  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rd_req,
  input  logic [2:0]       Op1_sel,
  input  logic [2:0]       Op2_sel,
  output logic             rd_ready,
  output logic             rd_valid,
  output logic [WIDTH-1:0] Op1_datafromReg,
  output logic [WIDTH-1:0] Op2_datafromReg,
  input  logic             rsv_en,
  input  logic [2:0]       rsv_sel,
  input  logic             wr_en,
  input  logic [2:0]       wr_sel,
  input  logic [WIDTH-1:0] wr_data,
  output logic [NREG-1:0]  pending,
  output logic             sel_err,
  output logic [WIDTH-1:0] acc_out
);

  logic [WIDTH-1:0] regs [NREG];
  logic [NREG-1:0]  pend_next;
  logic             wr_hit1, wr_hit2;
  logic             busy1, busy2;
  logic [WIDTH-1:0] op1_fwd, op2_fwd;

  function automatic logic [WIDTH-1:0] rst_val(int unsigned idx);
    case (idx)
      0:       return WIDTH'(10);
      1:       return WIDTH'(1000);
      2:       return WIDTH'(100);
      3:       return WIDTH'(1);
      4:       return WIDTH'(10000);
      5:       return WIDTH'(0);
      6:       return WIDTH'(500);
      7:       return WIDTH'(5000);
      default: return '0;
    endcase
  endfunction

  // A write landing this cycle both releases a pending operand and supplies its data.
  always_comb begin
    wr_hit1  = wr_en && (wr_sel == Op1_sel);
    wr_hit2  = wr_en && (wr_sel == Op2_sel);
    busy1    = pending[Op1_sel] && !wr_hit1;
    busy2    = pending[Op2_sel] && !wr_hit2;
    rd_ready = rd_req && (Op1_sel != Op2_sel) && !busy1 && !busy2;
    op1_fwd  = wr_hit1 ? wr_data : regs[Op1_sel];
    op2_fwd  = wr_hit2 ? wr_data : regs[Op2_sel];
  end

  // Reservation is applied after the write clear so a same-index reserve wins.
  always_comb begin
    pend_next = pending;
    if (wr_en)  pend_next[wr_sel]  = 1'b0;
    if (rsv_en) pend_next[rsv_sel] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) regs[i] <= rst_val(i);
      pending         <= '0;
      rd_valid        <= 1'b0;
      Op1_datafromReg <= '0;
      Op2_datafromReg <= '0;
      sel_err         <= 1'b0;
    end else begin
      if (wr_en) regs[wr_sel] <= wr_data;
      pending  <= pend_next;
      rd_valid <= rd_ready;
      if (rd_ready) begin
        Op1_datafromReg <= op1_fwd;
        Op2_datafromReg <= op2_fwd;
      end
      if (rd_req && (Op1_sel == Op2_sel)) sel_err <= 1'b1;
    end
  end

  assign acc_out = regs[0];

endmodule

// File: tb/tb_operand_reg_bank.sv
// Scoreboard bench for operand_reg_bank: stimulus pushes expected operand pairs,
// a negedge monitor pops and compares whenever rd_valid is presented.
module tb_operand_reg_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_req;
  logic [2:0]  Op1_sel, Op2_sel;
  logic        rd_ready, rd_valid;
  logic [15:0] Op1_datafromReg, Op2_datafromReg;
  logic        rsv_en;
  logic [2:0]  rsv_sel;
  logic        wr_en;
  logic [2:0]  wr_sel;
  logic [15:0] wr_data;
  logic [7:0]  pending;
  logic        sel_err;
  logic [15:0] acc_out;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [$];
  logic        mon_en = 1'b1;

  operand_reg_bank #(.WIDTH(16), .NREG(8)) dut (
    .clk(clk), .rst_n(rst_n), .rd_req(rd_req), .Op1_sel(Op1_sel), .Op2_sel(Op2_sel),
    .rd_ready(rd_ready), .rd_valid(rd_valid),
    .Op1_datafromReg(Op1_datafromReg), .Op2_datafromReg(Op2_datafromReg),
    .rsv_en(rsv_en), .rsv_sel(rsv_sel), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .pending(pending), .sel_err(sel_err), .acc_out(acc_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every presented rd_valid must match the oldest expected operand pair.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n === 1'b1 && rd_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid: got op1=%0h op2=%0h expected no valid",
                   Op1_datafromReg, Op2_datafromReg);
        end else begin
          e = exp_q.pop_front();
          if ({Op1_datafromReg, Op2_datafromReg} !== e) begin
            errors++;
            $display("FAIL operands: got %0h/%0h expected %0h/%0h",
                     Op1_datafromReg, Op2_datafromReg, e[31:16], e[15:0]);
          end
        end
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive an accepted request for one cycle and queue its expected operands.
  task automatic issue(input logic [2:0] s1, input logic [2:0] s2,
                       input logic [15:0] e1, input logic [15:0] e2);
    rd_req = 1'b1; Op1_sel = s1; Op2_sel = s2;
    #1;
    chk("rd_ready_accept", {31'd0, rd_ready}, 32'd1);
    exp_q.push_back({e1, e2});
    tick();
    rd_req = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; rd_req = 1'b0; Op1_sel = 3'd0; Op2_sel = 3'd0;
    rsv_en = 1'b0; rsv_sel = 3'd0; wr_en = 1'b0; wr_sel = 3'd0; wr_data = '0;
    #23;
    chk("rst_pending", {24'd0, pending}, 32'd0);
    chk("rst_valid", {31'd0, rd_valid}, 32'd0);
    chk("rst_ops", {Op1_datafromReg, Op2_datafromReg}, 32'd0);
    chk("rst_sel_err", {31'd0, sel_err}, 32'd0);
    chk("rst_acc", {16'd0, acc_out}, 32'd10);
    rst_n = 1'b1;

    // First request right after reset release.
    issue(3'd1, 3'd6, 16'd1000, 16'd500);
    chk("acc_after_read", {16'd0, acc_out}, 32'd10);

    // Write-to-read bypass, then storage read.
    wr_en = 1'b1; wr_sel = 3'd3; wr_data = 16'h1234;
    issue(3'd3, 3'd4, 16'h1234, 16'd10000);
    wr_en = 1'b0;
    issue(3'd3, 3'd0, 16'h1234, 16'd10);

    // Scoreboard stall on R2 until its write-back.
    rsv_en = 1'b1; rsv_sel = 3'd2;
    tick();
    rsv_en = 1'b0;
    chk("pending_r2", {24'd0, pending}, 32'h04);
    rd_req = 1'b1; Op1_sel = 3'd2; Op2_sel = 3'd0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_r2", {31'd0, rd_ready}, 32'd0);
      tick();
    end
    wr_en = 1'b1; wr_sel = 3'd2; wr_data = 16'd77;
    issue(3'd2, 3'd0, 16'd77, 16'd10);
    wr_en = 1'b0;
    chk("pending_clr_r2", {24'd0, pending}, 32'h00);

    // Same-cycle reserve and write on R5: stored, still pending.
    rsv_en = 1'b1; rsv_sel = 3'd5; wr_en = 1'b1; wr_sel = 3'd5; wr_data = 16'hBEEF;
    tick();
    rsv_en = 1'b0; wr_en = 1'b0;
    chk("pending_r5", {24'd0, pending}, 32'h20);
    rd_req = 1'b1; Op1_sel = 3'd5; Op2_sel = 3'd1;
    #1;
    chk("stall_r5", {31'd0, rd_ready}, 32'd0);
    tick();
    wr_en = 1'b1; wr_sel = 3'd5; wr_data = 16'h5555;
    issue(3'd5, 3'd1, 16'h5555, 16'd1000);
    wr_en = 1'b0;
    issue(3'd5, 3'd2, 16'h5555, 16'd77);

    // Same-cycle reserve and write on R0 is visible through acc_out.
    rsv_en = 1'b1; rsv_sel = 3'd0; wr_en = 1'b1; wr_sel = 3'd0; wr_data = 16'h00AA;
    #1;
    chk("acc_before_edge", {16'd0, acc_out}, 32'd10);
    tick();
    rsv_en = 1'b0; wr_en = 1'b0;
    chk("acc_written", {16'd0, acc_out}, 32'h00AA);
    chk("pending_r0", {24'd0, pending}, 32'h01);
    wr_en = 1'b1; wr_sel = 3'd0; wr_data = 16'h00AA;
    tick();
    wr_en = 1'b0;
    chk("pending_clr_r0", {24'd0, pending}, 32'h00);

    // Reserving a selected register in the accepting cycle still reads the old value.
    rsv_en = 1'b1; rsv_sel = 3'd6;
    issue(3'd6, 3'd7, 16'd500, 16'd5000);
    rsv_en = 1'b0;
    chk("pending_r6", {24'd0, pending}, 32'h40);
    wr_en = 1'b1; wr_sel = 3'd6; wr_data = 16'h0600;
    tick();
    wr_en = 1'b0;

    // Back-to-back requests, then operands hold while idle.
    issue(3'd1, 3'd2, 16'd1000, 16'd77);
    issue(3'd7, 3'd4, 16'd5000, 16'd10000);
    tick();
    chk("hold_ops", {Op1_datafromReg, Op2_datafromReg}, {16'd5000, 16'd10000});

    // Equal selects: rejected and sticky error.
    rd_req = 1'b1; Op1_sel = 3'd4; Op2_sel = 3'd4;
    #1;
    chk("eq_ready", {31'd0, rd_ready}, 32'd0);
    tick();
    rd_req = 1'b0;
    chk("sel_err_set", {31'd0, sel_err}, 32'd1);
    issue(3'd4, 3'd1, 16'd10000, 16'd1000);
    chk("sel_err_sticky", {31'd0, sel_err}, 32'd1);

    // Reset while rd_valid is high; monitor disabled so the dropped pulse is not expected.
    rd_req = 1'b1; Op1_sel = 3'd1; Op2_sel = 3'd6; rsv_en = 1'b1; rsv_sel = 3'd7;
    @(posedge clk);
    #1;
    rd_req = 1'b0; rsv_en = 1'b0; mon_en = 1'b0;
    chk("pre_rst_valid", {31'd0, rd_valid}, 32'd1);
    chk("pre_rst_op1", {16'd0, Op1_datafromReg}, 32'd1000);
    chk("pre_rst_pending", {24'd0, pending}, 32'h80);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, rd_valid}, 32'd0);
    chk("mid_rst_ops", {Op1_datafromReg, Op2_datafromReg}, 32'd0);
    chk("mid_rst_pending", {24'd0, pending}, 32'd0);
    chk("mid_rst_sel_err", {31'd0, sel_err}, 32'd0);
    chk("mid_rst_acc", {16'd0, acc_out}, 32'd10);
    @(negedge clk);
    rst_n = 1'b1; mon_en = 1'b1;
    issue(3'd7, 3'd3, 16'd5000, 16'd1);

    tick();
    tick();
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_reg_bank.md
# operand_reg_bank

- Eight-entry, 16-bit general register bank feeding the operand latches (Op1, Op2) of the 16-bit CPU datapath.
- Serves two operand reads per request, with one-cycle registered latency and a valid strobe.
- Accepts one write-back per cycle, with same-cycle write-to-read bypass.
- Tracks pending (reserved) destination registers so operands are never issued stale. R0 is the accumulator and is also exported continuously.

## Interface
Parameters:
- WIDTH, 16, data width of every register and data port
- NREG, 8, number of registers (select width fixed at 3 bits)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- rd_req  in  1  operand read request
- Op1_sel  in  3  register index for operand 1
- Op2_sel  in  3  register index for operand 2
- rd_ready  out  1  combinational; request accepted this cycle
- rd_valid  out  1  operands valid; one-cycle pulse
- Op1_datafromReg  out  16  operand 1 data
- Op2_datafromReg  out  16  operand 2 data
- rsv_en  in  1  reserve a destination register (mark pending)
- rsv_sel  in  3  register to reserve
- wr_en  in  1  write-back strobe
- wr_sel  in  3  write-back register index
- wr_data  in  16  write-back data
- pending  out  8  per-register pending bits
- sel_err  out  1  sticky error: request made with Op1_sel == Op2_sel
- acc_out  out  16  current value of R0

## Operation
- Reset values of the registers, applied asynchronously: R0=10, R1=1000, R2=100, R3=1, R4=10000, R5=0, R6=500, R7=5000.
- Reset values of outputs and state: pending=0, rd_valid=0, both operand outputs 0, sel_err=0, acc_out=10.
- Acceptance: rd_ready = rd_req AND (Op1_sel != Op2_sel) AND neither selected register is effectively pending.
- Effectively pending means the pending bit is set and there is no same-cycle wr_en to that index.
- Bypass: if wr_en targets a selected index in the accepting cycle, that operand takes wr_data. Otherwise it takes the stored value.
- Accepted request: operand outputs load at the next edge and rd_valid=1 for that one cycle.
- Rejected request: rd_valid=0 next cycle. The requester holds rd_req and the selects until rd_ready=1.
- Operand outputs hold their last value whenever rd_valid=0.
- Equal selects: when rd_req=1 and Op1_sel==Op2_sel, the request is never accepted and sel_err is set. sel_err clears only on reset.
- Write: wr_en stores wr_data into R[wr_sel] and clears pending[wr_sel]. A write to a non-pending register is legal and is stored.
- Reserve: rsv_en sets pending[rsv_sel] at the next edge.
- Reserve and write to the same index in the same cycle: data is stored and the pending bit stays set (the new reservation wins).
- Reserve of a selected register in the accepting cycle: the read is still accepted with the pre-reservation value. The reservation applies from the next cycle.
- Reserve of an already pending register: no change.
- acc_out is R0 storage, updated the cycle after a write to R0.
- Arithmetic: none. Data passes unmodified at full 16 bits.

## Timing
- Read latency is 1 cycle from the accepting edge to rd_valid and data.
- Back-to-back accepted requests give rd_valid high on consecutive cycles.
- A write in cycle N is visible from storage in cycle N+1. It is visible through bypass in cycle N.
- pending updates one edge after rsv_en or wr_en.
- Reset asserted mid-operation immediately returns every output and register to its reset value, including dropping an in-flight rd_valid.
- The first request is honoured on the first edge after rst_n deasserts.

## Test plan
- Reset then read (Op1_sel=1, Op2_sel=6): next cycle rd_valid=1, Op1=1000, Op2=500, acc_out=10.
- Bypass: wr_en to R3 with 0x1234 while reading (3,4) in the same cycle -> operands 0x1234 and 10000. The following read of R3 also returns 0x1234.
- Scoreboard stall: rsv_en R2, then hold a read of (2,0) -> rd_ready=0 until the write of 77 to R2. In that write cycle rd_ready=1, and the next cycle gives Op1=77, Op2=10.
- Same-cycle reserve and write on R5 -> R5 is stored and pending[5] remains 1. A read of R5 stalls.
- Equal selects (4,4) -> rd_ready=0 and sel_err=1, held after a later valid request. Only rst_n clears it.
- Assert rst_n low during a cycle with rd_valid=1 -> outputs are zero immediately, the bank reloads its constants and pending=0.
